// File: rtl/lif_neuron_chain.sv
// Chain of leaky integrate-and-fire neurons. Stage 0 integrates the external
// synaptic current; each later stage integrates either the previous stage's
// membrane potential (mode=0) or a fixed current when the previous stage
// spiked (mode=1). Every stage has a refractory countdown after it fires.
//
// Each stage is a two-state machine (INTEGRATE / REFRACTORY). The state is
// not stored separately: it is decoded from the refractory counter
// (non-zero means REFRACTORY).
//
// Handshake: there is no valid/ready pairing. en=1 advances every stage by
// one step on the rising edge. en=0 holds v, refr and spike_cnt and forces
// spike to 0, so a held pulse is never seen twice.
module lif_neuron_chain #(
  parameter int WIDTH      = 8,
  parameter int STAGES     = 5,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  parameter int W_SPIKE    = 128,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [WIDTH-1:0]  cfg_thresh,
  input  logic [WIDTH-1:0]  i_syn,
  output logic [WIDTH-1:0]  v_mem,
  output logic [STAGES-1:0] spike,
  output logic [CNT_W-1:0]  spike_cnt
);

  localparam logic [0:0]       ST_INTEGRATE = 1'b0;
  localparam logic [0:0]       ST_REFRACT   = 1'b1;
  localparam logic [7:0]       REFRACT_V    = 8'(REFRACT);
  localparam logic [WIDTH-1:0] W_SPIKE_V    = WIDTH'(W_SPIKE);
  localparam logic [WIDTH-1:0] V_SAT        = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  v_q      [STAGES];
  logic [WIDTH-1:0]  v_d      [STAGES];
  logic [7:0]        refr_q   [STAGES];
  logic [7:0]        refr_d   [STAGES];
  logic [STAGES-1:0] spike_q;
  logic [STAGES-1:0] spike_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [WIDTH-1:0]  stage_in [STAGES];
  logic [WIDTH-1:0]  leak     [STAGES];
  logic [WIDTH:0]    sum_w    [STAGES];
  logic [WIDTH-1:0]  sum_sat  [STAGES];
  logic [0:0]        stage_st [STAGES];

  // Select each stage's input from the registered state of the stage before it.
  always_comb begin
    stage_in[0] = i_syn;
    for (int k = 1; k < STAGES; k++) begin
      if (mode) begin
        stage_in[k] = spike_q[k-1] ? W_SPIKE_V : '0;
      end else begin
        stage_in[k] = v_q[k-1];
      end
    end
  end

  // Leak, saturating sum and state decode per stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      leak[k]     = v_q[k] - (v_q[k] >> LEAK_SHIFT);
      sum_w[k]    = {1'b0, leak[k]} + {1'b0, stage_in[k]};
      sum_sat[k]  = sum_w[k][WIDTH] ? V_SAT : sum_w[k][WIDTH-1:0];
      stage_st[k] = (refr_q[k] != 8'd0) ? ST_REFRACT : ST_INTEGRATE;
    end
  end

  // Per-stage next state: refractory countdown, fire or integrate.
  always_comb begin
    spike_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]    = v_q[k];
      refr_d[k] = refr_q[k];
      if (en) begin
        case (stage_st[k])
          ST_REFRACT: begin
            v_d[k]    = '0;
            refr_d[k] = refr_q[k] - 8'd1;
          end
          default: begin
            if (sum_sat[k] >= cfg_thresh) begin
              spike_d[k] = 1'b1;
              v_d[k]     = '0;
              refr_d[k]  = REFRACT_V;
            end else begin
              v_d[k]     = sum_sat[k];
            end
          end
        endcase
      end
    end
  end

  // Count last-stage spikes, stopping at the maximum value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (spike_d[STAGES-1] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset wins over en and clears everything in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= '0;
        refr_q[k] <= '0;
      end
      spike_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= v_d[k];
        refr_q[k] <= refr_d[k];
      end
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign v_mem     = v_q[STAGES-1];
  assign spike     = spike_q;
  assign spike_cnt = cnt_q;

endmodule
